// File: rtl/out_uart_pkg.sv
// Shared types, frame constants and character helpers for the out_uart hex dumper.
package out_uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] CR          = 8'h0D;
  localparam logic [7:0] LF          = 8'h0A;
  localparam int         FRAME_CHARS = 18;
  localparam logic [4:0] LAST_CHR    = 5'(FRAME_CHARS - 1);

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n <= 4'd9) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h41 + {4'h0, n - 4'd10};
  endfunction

  // Characters 0..15 are nibbles of v, most significant first; 16/17 are CR/LF.
  function automatic logic [7:0] frame_char(input logic [63:0] v, input logic [4:0] k);
    logic [63:0] s;
    s = v << {k[3:0], 2'b00};
    if (k == 5'd16) begin
      return CR;
    end
    if (k == 5'd17) begin
      return LF;
    end
    return hex_ascii(s[63:60]);
  endfunction

endpackage

// File: rtl/out_uart_tx.sv
// 8N1 byte serializer. A load during the last STOP cycle chains straight into
// the next START, so consecutive characters are exactly 10 bit periods apart.
//
// state    | meaning
// TX_IDLE  | line high, waiting for load
// TX_START | start bit (low)
// TX_DATA  | data bits, LSB first
// TX_STOP  | stop bit (high); done pulses in its final cycle
module out_uart_tx
  import out_uart_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] d,
  output logic       txd,
  output logic       done,
  output logic       busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  tx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tick;

  assign tick = (cnt == '0);
  assign busy = (state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    txd       = 1'b1;
    done      = 1'b0;
    case (state)
      TX_IDLE: begin
        if (load) begin
          state_nxt = TX_START;
          cnt_nxt   = BAUD_LAST;
          shift_nxt = d;
        end
      end
      TX_START: begin
        txd = 1'b0;
        if (tick) begin
          state_nxt = TX_DATA;
          cnt_nxt   = BAUD_LAST;
          bit_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      TX_DATA: begin
        txd = shift[bit_idx];
        if (tick) begin
          cnt_nxt = BAUD_LAST;
          if (bit_idx == 3'd7) begin
            state_nxt = TX_STOP;
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      TX_STOP: begin
        if (tick) begin
          done = 1'b1;
          if (load) begin
            state_nxt = TX_START;
            cnt_nxt   = BAUD_LAST;
            shift_nxt = d;
          end else begin
            state_nxt = TX_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/out_uart.sv
// Watches the CPU's 64-bit output register and dumps it as 16 hex chars + CR LF
// over UART whenever it changes or a dump is requested.
module out_uart
  import out_uart_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] d,
  input  logic        req,
  output logic        txd,
  output logic        busy
);

  logic [63:0] last;
  logic [63:0] shadow;
  logic [4:0]  chr_idx;
  logic        pend;

  logic        tx_busy;
  logic        tx_done;
  logic        tx_load;
  logic [7:0]  tx_byte;
  logic        idle;
  logic        changed;
  logic        trigger;
  logic        advance;

  assign idle    = !tx_busy;
  assign changed = (d != last);
  assign trigger = changed || req || pend;
  assign advance = tx_done && (chr_idx != LAST_CHR);
  assign busy    = tx_busy;

  // The first character comes straight from d so START begins the cycle after the trigger.
  always_comb begin
    tx_load = 1'b0;
    tx_byte = frame_char(shadow, chr_idx + 5'd1);
    if (idle && trigger) begin
      tx_load = 1'b1;
      tx_byte = frame_char(d, 5'd0);
    end else if (advance) begin
      tx_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last    <= '0;
      shadow  <= '0;
      pend    <= 1'b0;
      chr_idx <= '0;
    end else if (idle) begin
      if (trigger) begin
        shadow  <= d;
        last    <= d;
        pend    <= 1'b0;
        chr_idx <= '0;
      end
    end else begin
      if (req || changed) begin
        pend <= 1'b1;
      end
      if (advance) begin
        chr_idx <= chr_idx + 5'd1;
      end
    end
  end

  out_uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tx_load),
    .d    (tx_byte),
    .txd  (txd),
    .done (tx_done),
    .busy (tx_busy)
  );

endmodule

// File: tb/tb_out_uart.sv
// Directed bench for out_uart with a cycle-counting 8N1 receiver model (BAUD_DIV = 4).
`timescale 1ns/1ps
module tb_out_uart;

  localparam int BAUD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [63:0] d = '0;
  logic        txd;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rx_q[$];
  int         rx_cyc;
  bit         rx_on = 1'b0;
  logic [7:0] rx_byte;

  int viol;
  int bc;
  int gap;

  out_uart #(.BAUD_DIV(BAUD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (d),
    .req  (req),
    .txd  (txd),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Receiver: samples mid-bit, counting cycles from the first low sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (txd === 1'b0) begin
        rx_on  = 1'b1;
        rx_cyc = 0;
      end
    end else begin
      rx_cyc++;
      if (rx_cyc >= BAUD + BAUD/2 && rx_cyc < 9*BAUD && (rx_cyc % BAUD) == BAUD/2)
        rx_byte[rx_cyc/BAUD - 1] = txd;
      if (rx_cyc == 9*BAUD + BAUD/2) begin
        chk("stop_bit", 64'(txd), 64'd1);
        rx_q.push_back(rx_byte);
        rx_on = 1'b0;
      end
    end
  end

  task automatic wait_chars(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(rx_q.size()), 64'(n));
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int k = 0;
    while (busy !== lvl && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(busy), 64'(lvl));
  endtask

  task automatic expect_frame(input logic [63:0] v, input string tag);
    string      s;
    logic [7:0] e;
    logic [7:0] got;
    s = $sformatf("%016h", v);
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        e = s[i];
        if (e >= 8'h61) e = e - 8'h20;
      end else begin
        e = (i == 16) ? 8'h0D : 8'h0A;
      end
      got = 8'h00;
      if (rx_q.size() != 0) got = rx_q.pop_front();
      chk($sformatf("%s_c%0d", tag, i), 64'(got), 64'(e));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", 64'(txd), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // d stays 0: nothing should be sent
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) viol++;
    end
    chk("idle_d0", 64'(viol), 64'd0);
    chk("idle_d0_rx", 64'(rx_q.size()), 64'd0);

    // change to a full-range value: latency, busy length, content
    @(posedge clk); #1 d = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    chk("lat_pre_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("lat_busy", 64'(busy), 64'd1);
    chk("lat_start", 64'(txd), 64'd0);
    bc = 0;
    while (busy === 1'b1 && bc < 2000) begin
      bc++;
      @(negedge clk);
    end
    chk("busy_len", 64'(bc), 64'd720);
    wait_chars(18, 100, "f0123_n");
    expect_frame(64'h0123_4567_89AB_CDEF, "f0123");

    // req with unchanged d; second req while busy gives one more frame
    @(posedge clk); #1 d = 64'h2A;
    wait_chars(18, 1000, "f2a_chg_n");
    expect_frame(64'h2A, "f2a_chg");
    wait_busy(1'b0, 100, "f2a_chg_end");
    repeat (5) @(posedge clk);
    #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    chk("req_busy", 64'(busy), 64'd1);
    repeat (100) @(posedge clk);
    #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    wait_busy(1'b0, 1000, "req1_end");
    gap = 0;
    while (busy !== 1'b1 && gap < 20) begin
      gap++;
      @(negedge clk);
    end
    chk("req_gap", 64'(gap), 64'd1);
    wait_chars(36, 1000, "req_n");
    expect_frame(64'h2A, "req1");
    expect_frame(64'h2A, "req2");
    repeat (200) @(negedge clk);
    chk("req_extra", 64'(rx_q.size()), 64'd0);
    chk("req_idle", 64'(busy), 64'd0);

    // latest-wins during a frame
    @(posedge clk); #1 d = 64'h1;
    repeat (60) @(posedge clk);
    #1 d = 64'h2;
    repeat (60) @(posedge clk);
    #1 d = 64'h3;
    repeat (60) @(posedge clk);
    #1 d = 64'h4;
    wait_chars(36, 2000, "lw_n");
    expect_frame(64'h1, "lw1");
    expect_frame(64'h4, "lw4");
    repeat (200) @(negedge clk);
    chk("lw_extra", 64'(rx_q.size()), 64'd0);

    // reset during char 5, then a fresh full frame
    @(posedge clk); #1 d = 64'hFFFF_FFFF_FFFF_FFFF;
    wait_chars(5, 500, "rst_pre_n");
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_txd", 64'(txd), 64'd1);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    rx_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    wait_chars(18, 1000, "fff_n");
    expect_frame(64'hFFFF_FFFF_FFFF_FFFF, "fff");
    wait_busy(1'b0, 100, "fff_end");

    // nibble boundary 9/A, with req and change in the same cycle
    @(posedge clk); #1 d = 64'h9A9A_9A9A_9A9A_9A9A; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    wait_chars(18, 1000, "f9a_n");
    expect_frame(64'h9A9A_9A9A_9A9A_9A9A, "f9a");
    repeat (200) @(negedge clk);
    chk("f9a_single", 64'(rx_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
